bht_btb_predictor: RTL and testbench
====================================

# bht_btb_predictor

Parametrised per-PC branch predictor for the IF stage: a direct-mapped branch history table (BHT) of saturating counters plus a tagged branch target buffer (BTB). It replaces the single global saturating counter. Fetch gets a combinational taken/target prediction every cycle. EX writes back resolved outcomes one cycle at a time.

## Interface
- ENTRIES, 16: BHT/BTB entry count; power of two, 2..256
- CNT_BITS, 2: counter width, 2..4
- TAG_BITS, 8: BTB tag width
- GHR_BITS, 4: global history width, ≤ log2(ENTRIES); used only with GSHARE_EN
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- lookup_pc  in  32  PC of instruction in IF
- take_branch  out  1  predict taken
- predicted_destination  out  32  predicted target
- btb_hit  out  1  valid BTB entry with matching tag
- feedback_valid  in  1  resolved branch in EX, not stalled
- fb_pc  in  32  PC of resolved branch
- fb_taken  in  1  actual outcome
- fb_target  in  32  actual taken target

## Operation
- IDX = log2(ENTRIES). Index = pc[IDX+1:2]. Tag = pc[IDX+TAG_BITS+1:IDX+2].
- Per entry: counter cnt[CNT_BITS], btb_valid, btb_tag, btb_target[32].
- Lookup is combinational:
  - btb_hit = valid && tag match.
  - take_branch = btb_hit && cnt MSB.
  - predicted_destination = btb_hit ? target : 0.
- Update when feedback_valid=1, at entry index(fb_pc):
  - fb_taken=1: cnt increments, saturating at 2^CNT_BITS−1. BTB entry is written (valid=1, tag, fb_target), overwriting any alias.
  - fb_taken=0: cnt decrements, saturating at 0. BTB entry is untouched.
- Counters never wrap.
- feedback_valid=0: no state changes. fb_* inputs are don't-care.
- Reset values:
  - every cnt = 2^(CNT_BITS−1)−1 (weakly not-taken)
  - every btb_valid = 0
  - GHR = 0
  - Outputs: take_branch=0, btb_hit=0, predicted_destination=0 for any lookup_pc.
- Reset has priority over a simultaneous feedback_valid. That feedback is dropped.

## Timing
- Prediction: zero-cycle latency, combinational from lookup_pc and table state.
- Update: written at the rising edge where feedback_valid=1. Visible to lookups from the next cycle.
- Same-cycle lookup and update of the same index: lookup returns the pre-update value. No bypass.
- One feedback per cycle. Back-to-back feedback to the same index accumulates: each edge sees the previous edge's result.
- Reset asserted mid-operation: all state cleared at the next rising edge with rst_n=0. Outputs take reset values from that edge.

## Configuration
- GSHARE_EN defined:
  - Index = pc[IDX+1:2] XOR zero-extended GHR, for both lookup and update.
  - On each feedback_valid, GHR <= {GHR[GHR_BITS−2:0], fb_taken}.
  - The update index uses the GHR value before that shift.
  - BTB tag still comes from the PC only.
- GSHARE_EN undefined:
  - No GHR register.
  - Index is pure PC bits.

## Test plan
1. Reset, then lookup_pc=0x100 → take_branch=0, btb_hit=0, predicted_destination=0.
2. One feedback at fb_pc=0x100, taken, target 0x200 → next cycle lookup 0x100 gives btb_hit=1, cnt=2, take_branch=1, predicted_destination=0x200.
3. Saturation (CNT_BITS=2), all at PC 0x100:
   - 5 taken feedbacks → cnt=3.
   - 1 not-taken → take_branch=1.
   - 2 more not-taken → take_branch=0, cnt=0.
   - Further not-taken → cnt stays 0.
4. Aliasing (ENTRIES=16):
   - Train 0x100 taken, then lookup 0x140 (same index, different tag) → btb_hit=0, take_branch=0.
   - Then feedback 0x140 taken, target 0x300 → lookup 0x100 gives btb_hit=0.
5. Same-cycle feedback and lookup on PC 0x100 (cnt=1→2) → that cycle take_branch=0; next cycle take_branch=1. Then rst_n low for one cycle → all lookups return reset values.
6. GSHARE_EN, GHR_BITS=4:
   - 4 taken feedbacks at 0x100 → GHR=4'b1111.
   - Lookup 0x100 then reads index 0x0 XOR 0xF = 0xF.
   - Entry 0 is not consulted.

Source files
------------

// File: rtl/bht_btb_predictor.sv
// Per-PC branch predictor: direct-mapped table of saturating counters plus a tagged BTB.
// Optional gshare indexing (global history XOR PC index) is enabled by defining GSHARE_EN.
module bht_btb_predictor #(
    parameter int ENTRIES  = 16,
    parameter int CNT_BITS = 2,
    parameter int TAG_BITS = 8,
    parameter int GHR_BITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] lookup_pc,
    output logic        take_branch,
    output logic [31:0] predicted_destination,
    output logic        btb_hit,
    input  logic        feedback_valid,
    input  logic [31:0] fb_pc,
    input  logic        fb_taken,
    input  logic [31:0] fb_target
);

    localparam int IDX = $clog2(ENTRIES);
    localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
    localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_MAX >> 1;  // weakly not-taken

    typedef logic [IDX-1:0]      idx_t;
    typedef logic [TAG_BITS-1:0] tag_t;

    logic [CNT_BITS-1:0] r_cnt    [ENTRIES];
    logic [ENTRIES-1:0]  r_valid;
    tag_t                r_tag    [ENTRIES];
    logic [31:0]         r_target [ENTRIES];

    idx_t w_ghr_ext;
    idx_t w_lk_idx;
    idx_t w_fb_idx;
    tag_t w_lk_tag;
    tag_t w_fb_tag;
    logic w_unused_pc_bits;

`ifdef GSHARE_EN
    logic [GHR_BITS-1:0] r_ghr;

    assign w_ghr_ext = idx_t'(r_ghr);

    // History shifts after the update, so the same edge indexes with the old GHR.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ghr <= '0;
        end else if (feedback_valid) begin
            r_ghr <= (r_ghr << 1) | GHR_BITS'(fb_taken);
        end
    end
`else
    logic [GHR_BITS-1:0] w_unused_ghr;

    assign w_unused_ghr = '0;
    assign w_ghr_ext    = '0;
`endif

    assign w_lk_idx = lookup_pc[IDX+1:2] ^ w_ghr_ext;
    assign w_fb_idx = fb_pc[IDX+1:2] ^ w_ghr_ext;
    assign w_lk_tag = lookup_pc[IDX+TAG_BITS+1:IDX+2];
    assign w_fb_tag = fb_pc[IDX+TAG_BITS+1:IDX+2];

    assign w_unused_pc_bits = ^{lookup_pc, fb_pc};

    // Lookup reads the registered tables only; a same-cycle update is not bypassed.
    assign btb_hit               = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign take_branch           = btb_hit && r_cnt[w_lk_idx][CNT_BITS-1];
    assign predicted_destination = btb_hit ? r_target[w_lk_idx] : 32'h0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: every table entry is reset, since lookups must return clean values right after reset.
            for (int i = 0; i < ENTRIES; i++) begin
                r_cnt[i]    <= CNT_INIT;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
            end
            r_valid <= '0;
        end else if (feedback_valid) begin
            if (fb_taken) begin
                if (r_cnt[w_fb_idx] != CNT_MAX) begin
                    r_cnt[w_fb_idx] <= r_cnt[w_fb_idx] + CNT_BITS'(1);
                end
                r_valid[w_fb_idx]  <= 1'b1;
                r_tag[w_fb_idx]    <= w_fb_tag;
                r_target[w_fb_idx] <= fb_target;
            end else if (r_cnt[w_fb_idx] != '0) begin
                r_cnt[w_fb_idx] <= r_cnt[w_fb_idx] - CNT_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_bht_btb_predictor.sv
// Directed bench for bht_btb_predictor: vector table plus hand-written multi-cycle sequences.
// Define GSHARE_EN for both bench and design to exercise the gshare indexing checks.
module tb_bht_btb_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] lookup_pc;
    logic        take_branch;
    logic [31:0] predicted_destination;
    logic        btb_hit;
    logic        feedback_valid;
    logic [31:0] fb_pc;
    logic        fb_taken;
    logic [31:0] fb_target;

    int n_checks = 0;
    int n_fail   = 0;

    bht_btb_predictor #(
        .ENTRIES (16),
        .CNT_BITS(2),
        .TAG_BITS(8),
        .GHR_BITS(4)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .lookup_pc            (lookup_pc),
        .take_branch          (take_branch),
        .predicted_destination(predicted_destination),
        .btb_hit              (btb_hit),
        .feedback_valid       (feedback_valid),
        .fb_pc                (fb_pc),
        .fb_taken             (fb_taken),
        .fb_target            (fb_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fb_v;
        logic [31:0] fb_pc;
        logic        fb_t;
        logic [31:0] fb_tgt;
        logic [31:0] lk_pc;
        logic        e_take;
        logic        e_hit;
        logic [31:0] e_dest;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string name, input logic e_take, input logic e_hit,
                              input logic [31:0] e_dest);
        check({name, " take"}, 32'(take_branch), 32'(e_take));
        check({name, " hit"},  32'(btb_hit),     32'(e_hit));
        check({name, " dest"}, predicted_destination, e_dest);
    endtask

    // Drive one cycle of stimulus at the falling edge; sample just after the next rising edge.
    task automatic step(input logic fv, input logic [31:0] pc, input logic t,
                        input logic [31:0] tgt, input logic [31:0] lk);
        @(negedge clk);
        feedback_valid = fv;
        fb_pc          = pc;
        fb_taken       = t;
        fb_target      = tgt;
        lookup_pc      = lk;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        feedback_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[19];

        rst_n          = 1'b0;
        feedback_valid = 1'b0;
        fb_pc          = 32'h0;
        fb_taken       = 1'b0;
        fb_target      = 32'h0;
        lookup_pc      = 32'h100;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

`ifndef GSHARE_EN
        // Counter walk at 0x100 (index 0, tag 4); 0x140 aliases index 0 with tag 5.
        vecs[0]  = '{1'b0, 32'h100, 1'b0, 32'h0,   32'h100, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h100, 1'b1, 32'h200, 32'h100, 1'b1, 1'b1, 32'h200};
        vecs[2]  = '{1'b1, 32'h100, 1'b1, 32'h200, 32'h100, 1'b1, 1'b1, 32'h200};
        vecs[3]  = '{1'b1, 32'h100, 1'b1, 32'h200, 32'h100, 1'b1, 1'b1, 32'h200};
        vecs[4]  = '{1'b1, 32'h100, 1'b1, 32'h200, 32'h100, 1'b1, 1'b1, 32'h200};
        vecs[5]  = '{1'b1, 32'h100, 1'b1, 32'h200, 32'h100, 1'b1, 1'b1, 32'h200};
        vecs[6]  = '{1'b1, 32'h100, 1'b1, 32'h200, 32'h100, 1'b1, 1'b1, 32'h200};
        vecs[7]  = '{1'b1, 32'h100, 1'b0, 32'h0,   32'h100, 1'b1, 1'b1, 32'h200};
        vecs[8]  = '{1'b1, 32'h100, 1'b0, 32'h0,   32'h100, 1'b0, 1'b1, 32'h200};
        vecs[9]  = '{1'b1, 32'h100, 1'b0, 32'h0,   32'h100, 1'b0, 1'b1, 32'h200};
        vecs[10] = '{1'b1, 32'h100, 1'b0, 32'h0,   32'h100, 1'b0, 1'b1, 32'h200};
        vecs[11] = '{1'b1, 32'h100, 1'b0, 32'h0,   32'h100, 1'b0, 1'b1, 32'h200};
        vecs[12] = '{1'b1, 32'h100, 1'b1, 32'h200, 32'h100, 1'b0, 1'b1, 32'h200};
        vecs[13] = '{1'b1, 32'h100, 1'b1, 32'h200, 32'h100, 1'b1, 1'b1, 32'h200};
        vecs[14] = '{1'b0, 32'h0,   1'b0, 32'h0,   32'h140, 1'b0, 1'b0, 32'h0};
        vecs[15] = '{1'b1, 32'h140, 1'b1, 32'h300, 32'h100, 1'b0, 1'b0, 32'h0};
        vecs[16] = '{1'b0, 32'h0,   1'b0, 32'h0,   32'h140, 1'b1, 1'b1, 32'h300};
        vecs[17] = '{1'b0, 32'h0,   1'b0, 32'h0,   32'h104, 1'b0, 1'b0, 32'h0};
        vecs[18] = '{1'b0, 32'h104, 1'b1, 32'h999, 32'h104, 1'b0, 1'b0, 32'h0};

        for (int i = 0; i < 19; i++) begin
            step(vecs[i].fb_v, vecs[i].fb_pc, vecs[i].fb_t, vecs[i].fb_tgt, vecs[i].lk_pc);
            check_outs($sformatf("vec%0d", i), vecs[i].e_take, vecs[i].e_hit, vecs[i].e_dest);
        end

        // Same-cycle lookup and update at 0x100 with cnt 1 -> 2: old value seen until the edge.
        do_reset();
        step(1'b1, 32'h100, 1'b1, 32'h200, 32'h100);
        step(1'b1, 32'h100, 1'b0, 32'h0,   32'h100);
        check_outs("pre_same_cycle", 1'b0, 1'b1, 32'h200);
        @(negedge clk);
        feedback_valid = 1'b1;
        fb_pc          = 32'h100;
        fb_taken       = 1'b1;
        fb_target      = 32'h200;
        lookup_pc      = 32'h100;
        #1;
        check_outs("same_cycle_before_edge", 1'b0, 1'b1, 32'h200);
        @(posedge clk);
        #1;
        check_outs("same_cycle_after_edge", 1'b1, 1'b1, 32'h200);

        // Reset mid-run wins over a simultaneous feedback.
        @(negedge clk);
        rst_n          = 1'b0;
        feedback_valid = 1'b1;
        fb_pc          = 32'h140;
        fb_taken       = 1'b1;
        fb_target      = 32'h300;
        @(posedge clk);
        #1;
        check_outs("mid_reset_0x100", 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst_n          = 1'b1;
        feedback_valid = 1'b0;
        lookup_pc      = 32'h140;
        #1;
        check_outs("mid_reset_dropped_fb", 1'b0, 1'b0, 32'h0);
        // Counter back at 1 after reset, so a single taken makes it predict taken.
        step(1'b1, 32'h100, 1'b1, 32'h240, 32'h100);
        check_outs("post_reset_one_taken", 1'b1, 1'b1, 32'h240);
`else
        // Four taken feedbacks at 0x100 write indices 0,1,3,7 and leave GHR = 4'hF.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h100, 1'b1, 32'h200, 32'h100);
        end
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h100);
        check_outs("gshare_0x100_idx_f", 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h13C);
        check_outs("gshare_idx0_via_xor", 1'b1, 1'b1, 32'h200);
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h138);
        check_outs("gshare_idx1_via_xor", 1'b1, 1'b1, 32'h200);
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h128);
        check_outs("gshare_idx5_untouched", 1'b0, 1'b0, 32'h0);
        do_reset();
        lookup_pc = 32'h13C;
        #1;
        check_outs("gshare_reset", 1'b0, 1'b0, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
